axi4lite_slave_regfile: RTL
===========================

// Module: axi4lite_slave_regfile
// PURPOSE
//  AXI4-Lite responder (slave) holding NUM_REGS 32-bit registers; the target
//  end of the M_AXI initiator path. Accepts single-beat writes and reads,
//  applies WSTRB byte enables and returns SLVERR for out-of-range addresses.
//  Counts completed writes and reads for bench and status visibility.
// PARAMETERS
//  C_S_AXI_ADDR_WIDTH  6   byte-address width (must cover NUM_REGS*4)
//  NUM_REGS            4   register count, power of 2, >=2
//  CNT_WIDTH           16  width of WR_COUNT / RD_COUNT
// PORTS
//  ACLK           in   1     clock; all logic on rising edge
//  ARESET         in   1     asynchronous reset, active-high
//  S_AXI_AWADDR   in   AW    write address (AW = C_S_AXI_ADDR_WIDTH)
//  S_AXI_AWPROT   in   3     ignored
//  S_AXI_AWVALID  in   1     write-address valid
//  S_AXI_AWREADY  out  1     write-address ready
//  S_AXI_WDATA    in   32    write data
//  S_AXI_WSTRB    in   4     byte enables; bit k -> WDATA[8k+7:8k]
//  S_AXI_WVALID   in   1     write-data valid
//  S_AXI_WREADY   out  1     write-data ready
//  S_AXI_BRESP    out  2     2'b00 OKAY, 2'b10 SLVERR
//  S_AXI_BVALID   out  1     write response valid
//  S_AXI_BREADY   in   1     write response ready
//  S_AXI_ARADDR   in   AW    read address
//  S_AXI_ARPROT   in   3     ignored
//  S_AXI_ARVALID  in   1     read-address valid
//  S_AXI_ARREADY  out  1     read-address ready
//  S_AXI_RDATA    out  32    read data
//  S_AXI_RRESP    out  2     2'b00 OKAY, 2'b10 SLVERR
//  S_AXI_RVALID   out  1     read data valid
//  S_AXI_RREADY   in   1     read data ready
//  WR_COUNT       out  CNT_WIDTH  completed B handshakes, wraps
//  RD_COUNT       out  CNT_WIDTH  completed R handshakes, wraps
// BEHAVIOUR
//  Reset (async, ARESET=1): all READY/VALID low, BRESP/RRESP=0, RDATA=0,
//   registers=0, counters=0, held-AW/W flags cleared; in-flight txns dropped.
//   First READY may rise the cycle after ARESET deasserts.
//  Decode: idx = ADDR[2 +: log2(NUM_REGS)]; ADDR[1:0] ignored;
//   ADDR >= NUM_REGS*4 -> out of range.
//  Write path, one outstanding: AWREADY = !aw_held & !BVALID;
//   WREADY = !w_held & !BVALID. AW and W handshake independently, any order.
//   Handshaked address/data latched into aw_held / w_held.
//  Commit edge = first edge at which both AW and W are held or handshaking.
//   At it: byte lanes with WSTRB=1 written (in range only), BVALID<=1,
//   BRESP<=OKAY or SLVERR, held flags cleared. Latency: BVALID high the
//   cycle after the later of the AW/W handshakes.
//  BVALID/BRESP stable until BREADY; on B handshake BVALID<=0 and
//   WR_COUNT+=1 (mod 2^CNT_WIDTH). WSTRB=0 in range -> no change, OKAY.
//  Read path, one outstanding: ARREADY = !RVALID. On AR handshake:
//   RDATA<=reg[idx] (or 0 if out of range), RRESP<=OKAY/SLVERR, RVALID<=1
//   (1-cycle latency). RDATA/RRESP stable until RREADY; on R handshake
//   RVALID<=0, RD_COUNT+=1 (mod 2^CNT_WIDTH).
//  Read and write paths fully independent; same-edge read and commit to
//   same register -> RDATA returns pre-write value.
//  No combinational path from any input to any output.
// TESTING
//  T1 write 1,2,3,4 to 0x0,0x4,0x8,0xC (WSTRB=F), read back -> RDATA
//     1,2,3,4, all BRESP/RRESP=00, WR_COUNT=4, RD_COUNT=4.
//  T2 reg0=0x11223344; write 0xAABBCCDD WSTRB=4'b0101 -> read 0x11BB33DD.
//  T3 write to 0x10 (NUM_REGS=4) -> BRESP=10, regs unchanged; read 0x10
//     -> RDATA=0, RRESP=10.
//  T4 AWVALID 3 cycles before WVALID, then W before AW -> AWREADY low
//     while held, BVALID exactly 1 cycle after second handshake, data OK.
//  T5 BREADY/RREADY held low 5 cycles -> VALID+payload stable, no new
//     AW/W/AR accepted; counters increment once on release.
//  T6 assert ARESET while aw_held=1 and BVALID pending -> all outputs 0
//     immediately, regs 0; next full write completes normally.

Source files
------------

// File: rtl/axi4lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// axi4lite_slave_regfile
//
// AXI4-Lite responder holding NUM_REGS 32-bit registers. Single-beat writes
// (with WSTRB byte enables) and reads, one outstanding transaction per
// direction. Addresses at or beyond NUM_REGS*4 answer SLVERR: writes are
// dropped, reads return zero. Completed B and R handshakes are counted.
//
// Ports
//   ACLK, ARESET            clock (rising edge), async active-high reset
//   S_AXI_AW*               write address channel (AWPROT ignored)
//   S_AXI_W*                write data channel
//   S_AXI_B*                write response channel
//   S_AXI_AR*               read address channel (ARPROT ignored)
//   S_AXI_R*                read data channel
//   WR_COUNT / RD_COUNT     completed B / R handshakes, wrapping
//
// Write-path FSM
//   state       | meaning
//   WR_IDLE     | nothing held, AW and W both accepted
//   WR_AW_HELD  | address captured, waiting for data
//   WR_W_HELD   | data captured, waiting for address
//   WR_RESP     | write committed, BVALID high until BREADY
// ---------------------------------------------------------------------------
module axi4lite_slave_regfile #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [CNT_WIDTH-1:0]          WR_COUNT,
  output logic [CNT_WIDTH-1:0]          RD_COUNT
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [AW:0] ADDR_LIMIT  = (AW+1)'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_AW_HELD = 2'd1,
    WR_W_HELD  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  wr_state_t              wr_state;
  wr_state_t              wr_state_nxt;

  // Held low through reset and released one edge later, so no READY is
  // ever visible while ARESET is high.
  logic                   ready_en;

  logic                   awready_c;
  logic                   wready_c;
  logic                   bvalid_c;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   commit;

  logic [AW-1:0]          aw_addr_q;
  logic [31:0]            w_data_q;
  logic [3:0]             w_strb_q;

  logic [AW-1:0]          wr_addr;
  logic [31:0]            wr_data;
  logic [3:0]             wr_strb;
  logic                   wr_in_range;
  logic [IDX_W-1:0]       wr_idx;

  logic [1:0]             bresp_q;
  logic [CNT_WIDTH-1:0]   wr_count_q;

  logic [31:0]            regs [NUM_REGS];

  logic                   arready_c;
  logic                   ar_hs;
  logic                   rd_in_range;
  logic [IDX_W-1:0]       rd_idx;
  logic                   rvalid_q;
  logic [31:0]            rdata_q;
  logic [1:0]             rresp_q;
  logic [CNT_WIDTH-1:0]   rd_count_q;

  logic                   unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Write-path FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= WR_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
    end
  end

  // Commit fires on the edge where the second of AW/W is handshaking while
  // the first is either handshaking too or already held.
  always_comb begin
    wr_state_nxt = wr_state;
    commit       = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_nxt = WR_RESP;
          commit       = 1'b1;
        end else if (aw_hs) begin
          wr_state_nxt = WR_AW_HELD;
        end else if (w_hs) begin
          wr_state_nxt = WR_W_HELD;
        end
      end
      WR_AW_HELD: begin
        if (w_hs) begin
          wr_state_nxt = WR_RESP;
          commit       = 1'b1;
        end
      end
      WR_W_HELD: begin
        if (aw_hs) begin
          wr_state_nxt = WR_RESP;
          commit       = 1'b1;
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          wr_state_nxt = WR_IDLE;
        end
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    awready_c = 1'b0;
    wready_c  = 1'b0;
    bvalid_c  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        awready_c = ready_en;
        wready_c  = ready_en;
      end
      WR_AW_HELD: wready_c  = ready_en;
      WR_W_HELD:  awready_c = ready_en;
      WR_RESP:    bvalid_c  = 1'b1;
      default: begin
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
      end
    endcase
  end

  assign aw_hs = S_AXI_AWVALID & awready_c;
  assign w_hs  = S_AXI_WVALID  & wready_c;

  // -------------------------------------------------------------------------
  // Write datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // At commit the held half comes from the capture registers, the other
  // half straight from the bus.
  assign wr_addr     = (wr_state == WR_AW_HELD) ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data     = (wr_state == WR_W_HELD)  ? w_data_q  : S_AXI_WDATA;
  assign wr_strb     = (wr_state == WR_W_HELD)  ? w_strb_q  : S_AXI_WSTRB;
  assign wr_in_range = ({1'b0, wr_addr} < ADDR_LIMIT);
  assign wr_idx      = wr_addr[2 +: IDX_W];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bresp_q    <= RESP_OKAY;
      wr_count_q <= '0;
    end else begin
      if (commit) begin
        bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if ((wr_state == WR_RESP) && S_AXI_BREADY) begin
        wr_count_q <= wr_count_q + CNT_WIDTH'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  assign arready_c   = ready_en & ~rvalid_q;
  assign ar_hs       = S_AXI_ARVALID & arready_c;
  assign rd_in_range = ({1'b0, S_AXI_ARADDR} < ADDR_LIMIT);
  assign rd_idx      = S_AXI_ARADDR[2 +: IDX_W];

  // regs[] is sampled before any same-edge commit lands, so a colliding
  // read returns the pre-write value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_count_q <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_in_range ? regs[rd_idx] : 32'h0;
      rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q   <= 1'b0;
      rd_count_q <= rd_count_q + CNT_WIDTH'(1);
    end
  end

  assign S_AXI_AWREADY = awready_c;
  assign S_AXI_WREADY  = wready_c;
  assign S_AXI_BVALID  = bvalid_c;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_c;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign WR_COUNT      = wr_count_q;
  assign RD_COUNT      = rd_count_q;

endmodule
